// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_KBD             = 0;
    localparam int unsigned REQ_ECHO            = 1;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 65535;
    localparam int unsigned WDOG_W              = 16;

endpackage

// File: rtl/tx_watchdog.sv
// Cycle counter for one transmit; raises a registered expire flag while the
// count sits at TIMEOUT_CYC-1.
module tx_watchdog
    import uart_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // expire is set on the same edge that moves count onto TIMEOUT_CYC-1
    localparam logic [WDOG_W-1:0] PRE_EXPIRE = WDOG_W'(TIMEOUT_CYC - 2);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            expire <= 1'b0;
        end else if (enable) begin
            count  <= count + WDOG_W'(1);
            expire <= (count == PRE_EXPIRE);
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the keyboard
// scan-code buffer (requester 0) and the rx echo buffer (requester 1).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_flag,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_clr,
    output logic       tx_start,
    output logic [7:0] tx_din,
    input  logic       tx_done_tick,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err_tick
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       pick;
    logic       grant_edge;
    logic       in_send;
    logic       wdog_expire;

    logic [1:0] req_clr_nxt;
    logic       tx_start_nxt;
    logic [7:0] tx_din_nxt;
    logic [1:0] grant_nxt;
    logic       busy_nxt;
    logic       err_tick_nxt;

    assign in_send    = (state == ST_SEND);
    assign grant_edge = (state == ST_IDLE) && (req_flag != 2'b00);

    // With both flags up the requester not served last time wins.
    always_comb begin
        if (req_flag == 2'b11)
            pick = ~last;
        else
            pick = req_flag[REQ_ECHO];
    end

    tx_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clear (grant_edge),
        .enable(in_send),
        .expire(wdog_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            req_clr  <= '0;
            tx_start <= 1'b0;
            tx_din   <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            err_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            req_clr  <= req_clr_nxt;
            tx_start <= tx_start_nxt;
            tx_din   <= tx_din_nxt;
            grant    <= grant_nxt;
            busy     <= busy_nxt;
            err_tick <= err_tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_flag != 2'b00) state_nxt = ST_SEND;
            ST_SEND: if (tx_done_tick || wdog_expire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        last_nxt     = last;
        req_clr_nxt  = '0;
        tx_start_nxt = 1'b0;
        tx_din_nxt   = tx_din;
        grant_nxt    = grant;
        busy_nxt     = busy;
        err_tick_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_flag != 2'b00) begin
                    tx_din_nxt   = pick ? req_data1 : req_data0;
                    tx_start_nxt = 1'b1;
                    req_clr_nxt  = pick ? 2'b10 : 2'b01;
                    grant_nxt    = pick ? 2'b10 : 2'b01;
                    last_nxt     = pick;
                    busy_nxt     = 1'b1;
                end
            end
            ST_SEND: begin
                // completion takes priority over a coincident watchdog expiry
                if (tx_done_tick) begin
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end else if (wdog_expire) begin
                    err_tick_nxt = 1'b1;
                    grant_nxt    = '0;
                    busy_nxt     = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: a long-timeout instance for
// arbitration and a short-timeout instance for watchdog behaviour.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] din;
        logic [1:0] clr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;

    logic [1:0] flag = 2'b00;
    logic [1:0] set_req;
    logic [7:0] data0, data1;
    logic [1:0] req_clr;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       done;
    logic [1:0] grant;
    logic       busy;
    logic       err_tick;

    logic [1:0] wd_flag;
    logic [7:0] wd_data0, wd_data1;
    logic [1:0] wd_req_clr;
    logic       wd_tx_start;
    logic [7:0] wd_tx_din;
    logic       wd_done;
    logic [1:0] wd_grant;
    logic       wd_busy;
    logic       wd_err_tick;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Flag buffer model: clear wins over a same-cycle set.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req_clr[i])      flag[i] <= 1'b0;
            else if (set_req[i]) flag[i] <= 1'b1;
        end
    end

    uart_tx_arbiter #(.TIMEOUT_CYC(64)) u_dut (
        .clk(clk), .reset(reset), .req_flag(flag), .req_data0(data0), .req_data1(data1),
        .req_clr(req_clr), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(done),
        .grant(grant), .busy(busy), .err_tick(err_tick)
    );

    uart_tx_arbiter #(.TIMEOUT_CYC(8)) u_wd (
        .clk(clk), .reset(reset), .req_flag(wd_flag), .req_data0(wd_data0), .req_data1(wd_data1),
        .req_clr(wd_req_clr), .tx_start(wd_tx_start), .tx_din(wd_tx_din), .tx_done_tick(wd_done),
        .grant(wd_grant), .busy(wd_busy), .err_tick(wd_err_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_set(input logic [1:0] bits);
        set_req = bits;
        step();
        set_req = 2'b00;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int max_cyc);
        exp_t e;
        int   n = 0;
        while (tx_start !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_start"}, 16'(tx_start), 16'h1);
        if (tx_start === 1'b1) begin
            check({tag, "_sb_nonempty"}, 16'(q.size() != 0), 16'h1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({tag, "_grant"}, 16'(grant), 16'(e.grant));
                check({tag, "_din"},   16'(tx_din), 16'(e.din));
                check({tag, "_clr"},   16'(req_clr), 16'(e.clr));
                check({tag, "_busy"},  16'(busy), 16'h1);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] din_exp);
        check({tag, "_req_clr"},  16'(req_clr), 16'h0);
        check({tag, "_tx_start"}, 16'(tx_start), 16'h0);
        check({tag, "_tx_din"},   16'(tx_din), 16'(din_exp));
        check({tag, "_grant"},    16'(grant), 16'h0);
        check({tag, "_busy"},     16'(busy), 16'h0);
        check({tag, "_err"},      16'(err_tick), 16'h0);
    endtask

    initial begin
        reset = 1'b0; set_req = 2'b00; done = 1'b0; data0 = 8'h00; data1 = 8'h00;
        wd_flag = 2'b00; wd_done = 1'b0; wd_data0 = 8'h5A; wd_data1 = 8'hA5;
        step(); step();
        check_idle_outputs("rst", 8'h00);
        check("rst_wd_grant", 16'(wd_grant), 16'h0);
        check("rst_wd_err",   16'(wd_err_tick), 16'h0);
        reset = 1'b1;
        step();

        // single request from the keyboard buffer
        data0 = 8'hE2;
        pulse_set(2'b01);
        q.push_back('{grant: 2'b01, din: 8'hE2, clr: 2'b01});
        wait_start("single", 4);
        step();
        check("single_start_width", 16'(tx_start), 16'h0);
        check("single_clr_width",   16'(req_clr), 16'h0);
        check("single_flag_dropped", 16'(flag), 16'h0);
        repeat (18) step();
        check("single_busy_hold", 16'(busy), 16'h1);
        pulse_done();
        check_idle_outputs("single_end", 8'hE2);

        // simultaneous requests straight after reset
        reset = 1'b0; step(); reset = 1'b1;
        data0 = 8'h11; data1 = 8'h33;
        pulse_set(2'b11);
        q.push_back('{grant: 2'b01, din: 8'h11, clr: 2'b01});
        q.push_back('{grant: 2'b10, din: 8'h33, clr: 2'b10});
        wait_start("both_a", 4);
        repeat (5) step();
        pulse_done();
        check("both_busy_low", 16'(busy), 16'h0);
        check("both_no_early_start", 16'(tx_start), 16'h0);
        step();
        wait_start("both_b", 0);
        repeat (5) step();
        pulse_done();

        // fairness with both flags re-set after every clear
        pulse_set(2'b11);
        for (int i = 0; i < 6; i++) begin
            q.push_back('{grant: (i % 2 == 0) ? 2'b01 : 2'b10,
                          din:   (i % 2 == 0) ? 8'h11 : 8'h33,
                          clr:   (i % 2 == 0) ? 2'b01 : 2'b10});
            wait_start($sformatf("fair%0d", i), 4);
            step();
            if (i < 5) pulse_set((i % 2 == 0) ? 2'b01 : 2'b10);
            repeat (3) step();
            pulse_done();
        end
        q.push_back('{grant: 2'b01, din: 8'h11, clr: 2'b01});
        wait_start("flush", 4);
        repeat (3) step();
        pulse_done();
        repeat (2) step();
        check("flush_idle", 16'(busy), 16'h0);

        // reset in the middle of a transfer, flag1 re-asserted during SEND
        pulse_set(2'b10);
        q.push_back('{grant: 2'b10, din: 8'h33, clr: 2'b10});
        wait_start("mid_a", 4);
        step();
        pulse_set(2'b10);
        reset = 1'b0;
        #1;
        check_idle_outputs("mid_rst", 8'h00);
        step();
        reset = 1'b1;
        q.push_back('{grant: 2'b10, din: 8'h33, clr: 2'b10});
        wait_start("mid_b", 4);
        repeat (3) step();
        pulse_done();
        check("mid_end_busy", 16'(busy), 16'h0);
        check("sb_empty", 16'(q.size()), 16'h0);

        // watchdog abort on the short-timeout instance
        wd_flag = 2'b10;
        step();
        check("to_start", 16'(wd_tx_start), 16'h1);
        check("to_grant", 16'(wd_grant), 16'h2);
        check("to_din",   16'(wd_tx_din), 16'hA5);
        check("to_clr",   16'(wd_req_clr), 16'h2);
        wd_flag = 2'b00;
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("to_quiet%0d", k), 16'(wd_err_tick), 16'h0);
        end
        step();
        check("to_err",   16'(wd_err_tick), 16'h1);
        check("to_grant0", 16'(wd_grant), 16'h0);
        check("to_busy0",  16'(wd_busy), 16'h0);
        step();
        check("to_err_width", 16'(wd_err_tick), 16'h0);
        wd_done = 1'b1; step(); wd_done = 1'b0;
        check("late_done_start", 16'(wd_tx_start), 16'h0);
        check("late_done_busy",  16'(wd_busy), 16'h0);
        step();
        check("late_done_err",   16'(wd_err_tick), 16'h0);

        // done coincident with the last watchdog cycle
        wd_flag = 2'b01;
        step();
        check("co_start", 16'(wd_tx_start), 16'h1);
        check("co_grant", 16'(wd_grant), 16'h1);
        wd_flag = 2'b00;
        repeat (7) step();
        wd_done = 1'b1; step(); wd_done = 1'b0;
        check("co_err",  16'(wd_err_tick), 16'h0);
        check("co_busy", 16'(wd_busy), 16'h0);
        check("co_grant0", 16'(wd_grant), 16'h0);
        step();
        check("co_err_after", 16'(wd_err_tick), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two flag-buffered byte sources: requester 0 is the keyboard scan-code buffer, requester 1 is the UART-receive echo buffer. Watches both buffer flags, grants round-robin, loads the byte into the transmitter with a start pulse, and clears the granted buffer's flag. Waits for transmit completion before the next grant, and aborts on a watchdog timeout. Sits between the two flag buffers and the UART TX module in the keyboard-to-monitor top level.

## Interface
- TIMEOUT_CYC, 65535: max cycles in SEND before abort; legal range 2..65535.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_flag  in  2  flag outputs of the buffers; bit 0 = keyboard, bit 1 = rx echo.
- req_data0  in  8  data output of buffer 0.
- req_data1  in  8  data output of buffer 1.
- req_clr  out  2  one-cycle clear pulse to the granted buffer's clr_flag.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_din  out  8  byte to transmit; held stable from tx_start until leaving SEND.
- tx_done_tick  in  1  one-cycle completion pulse from the transmitter.
- grant  out  2  one-hot owner of the current transfer; 00 when idle.
- busy  out  1  high while in SEND.
- err_tick  out  1  one-cycle pulse on watchdog abort.

## Operation
- All outputs registered. Reset values: req_clr=00, tx_start=0, tx_din=0x00, grant=00, busy=0, err_tick=0, state=IDLE, last=1, wdog=0.
- States: IDLE, SEND.
- IDLE, no flag set: hold; all pulses low.
- IDLE, exactly one flag set: grant that requester.
- IDLE, both flags set: grant the requester not equal to `last`. After reset, requester 0 wins.
- Grant edge actions:
  - tx_din <= selected data.
  - tx_start <= 1.
  - req_clr[g] <= 1.
  - grant <= one-hot g.
  - last <= g.
  - busy <= 1.
  - wdog <= 0.
  - state <= SEND.
- SEND:
  - tx_start and req_clr return to 0 after one cycle.
  - wdog increments each cycle.
  - Flags are not sampled.
- SEND, tx_done_tick=1: state <= IDLE, grant <= 00, busy <= 0. tx_din is not cleared.
- SEND, wdog == TIMEOUT_CYC-1 without done: err_tick <= 1 for one cycle, then same exit as done.
- Done and timeout in the same cycle: done wins; no err_tick.
- tx_done_tick while in IDLE: ignored.
- A flag that re-asserts during SEND, by a new set_flag on that buffer, is served after return to IDLE under round-robin.
- Reset asserted mid-SEND: immediate return to reset values. No clear pulse is issued. The buffer flag state is owned by the buffers' own reset.

## Timing
- Flag high in IDLE at cycle N: tx_start, req_clr and grant are visible in cycle N+1. The buffer flag drops at N+2.
- tx_done_tick at cycle M: busy=0 at M+1. The earliest next tx_start is M+2, giving one IDLE cycle of sampling.
- The one IDLE cycle guarantees the cleared flag is not re-sampled.
- Back-to-back service with both flags held: grants alternate 0,1,0,1.
- Watchdog abort: err_tick is high in cycle N+1+TIMEOUT_CYC, measured from tx_start at N+1.
- tx_start and req_clr are each exactly one cycle wide; never asserted outside a grant edge.

## Structure
- Shared package `uart_arb_pkg`:
  - State encoding localparams ST_IDLE, ST_SEND.
  - Requester indices REQ_KBD=0, REQ_ECHO=1.
  - Default TIMEOUT_CYC.
- One natural sub-module, `tx_watchdog`:
  - 16-bit counter with clear and enable.
  - Registered expire output at TIMEOUT_CYC-1.
  - Same async active-low reset.
- Round-robin pick stays inline in the arbiter.

## Test plan
- Single request: after reset, flag0=1, data0=0xE2:
  - tx_start and req_clr=01 one cycle later; tx_din=0xE2, grant=01.
  - tx_done_tick after 20 cycles -> busy=0 the next cycle.
- Simultaneous requests: both flags high, data0=0x11, data1=0x33, done after each:
  - tx_din sequence 0x11 then 0x33.
  - req_clr 01 then 10.
  - Second tx_start exactly 2 cycles after the first done.
- Fairness: both flags re-set immediately after every clear, for 6 transfers -> grant sequence 01,10,01,10,01,10.
- Timeout with TIMEOUT_CYC=8: flag1=1 and no done:
  - err_tick one cycle at 8 cycles after tx_start.
  - Then grant=00 and busy=0.
  - A late tx_done_tick is ignored.
- Reset mid-SEND: reset low for 1 cycle during SEND:
  - All outputs return to reset values asynchronously.
  - After release with flag1 still high, requester 1 is served (last=1 rule still picks the only flag).
- Done coincident with timeout: tx_done_tick on wdog=TIMEOUT_CYC-1 -> err_tick stays 0.
